contador_bcd: RTL and testbench
===============================

Name: contador_bcd

Overview:
- Single-digit synchronous BCD counter. Counts 0..9 on each rising clock edge and wraps to 0.
- Building block for cascaded time-of-day counters (minute/hour units and tens digits). A higher digit is clocked from a signal derived from the lower digit's count, or chained through tc.
- Parent logic forces truncated ranges (e.g. tens-of-minutes 0..5, hours 00..23) by driving reset. The block itself only wraps at MAX_COUNT.

Parameters:
- WIDTH, 4, width of count output q; must be >= 4.
- MAX_COUNT, 9, terminal value; the count wraps from MAX_COUNT to 0; legal range 1..(2^WIDTH - 1).

Ports:
- clk  input  1  counter clock; all state changes except reset occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; forces q to 0.
- en  input  1  count enable, active-high; tie to 1 when unused.
- up  input  1  direction: 1 = increment, 0 = decrement; tie to 1 when unused.
- load  input  1  synchronous parallel load, active-high; tie to 0 when unused.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
  - up=1: high when q == MAX_COUNT.
  - up=0: high when q == 0.

Behaviour:
- Reset:
  - reset low forces q = 0 immediately, independent of clk, and holds it while low.
  - tc then follows the q = 0 rule.
  - On reset deassertion, q stays 0 until the next rising clk edge with an action.
  - Reset asserted mid-count aborts the count; no partial update.
- Priority on each rising clk edge (reset high): load > en > hold.
  - load=1: q <= d when d <= MAX_COUNT; q <= 0 when d > MAX_COUNT. Load ignores en.
  - en=1, up=1: q <= q+1 when q < MAX_COUNT; q <= 0 when q >= MAX_COUNT. This covers wrap 9->0 and recovery from illegal codes 10..15.
  - en=1, up=0: q <= q-1 when 0 < q <= MAX_COUNT; q <= MAX_COUNT when q == 0; q <= MAX_COUNT when q > MAX_COUNT.
  - en=0, load=0: q holds.
- Latency: q updates one edge after the qualifying inputs; no pipeline.
- q never exceeds MAX_COUNT after reset or after any clock edge.
- Cascading contract:
  - Parent may clock a higher digit with the inverted "q >= MAX_COUNT" of a lower digit. That signal rises exactly when the lower digit wraps to 0, so the higher digit increments once per lower-digit wrap.
  - tc is glitch-free relative to q (decoded directly from the register).
- Reset deasserting on the same edge as clk: q is 0 at that edge; counting resumes from the following edge.
- Inputs en, up, load and d must be stable around the rising clk edge; no other timing assumptions.

Test Plan:
1. Pulse reset low for 1 time unit while q=5, between clock edges -> q=0 immediately, before any clk edge; tc=0.
2. Reset released, en=1, up=1, 12 rising edges -> q sequence 1,2,…,9,0,1,2. tc=1 only while q=9.
3. Cascade two instances: second's clk = ~(first.q >= 9); 25 edges on the first -> first.q=5, second.q=2. Second increments exactly on the first's 9->0 transitions.
4. load=1, d=7 with en=0 -> q=7 after one edge. load with d=12 -> q=0. load and en both high with d=3 -> q=3.
5. up=0, en=1 starting at q=2, 4 edges -> 1,0,9,8. tc=1 only while q=0.
6. en=0 for 5 edges at q=4 -> q stays 4. Parameter MAX_COUNT=5 build, counting up from 0 -> 0..5 then 0; tc=1 while q=5.

Source files
------------

// File: rtl/contador_bcd.sv
// contador_bcd: single-digit up/down counter with synchronous load, wrapping
// at MAX_COUNT (BCD digit 0..9 by default). Intended as a building block for
// cascaded time-of-day counters; parents truncate ranges by driving reset.
//
// Ports:
//   clk    counter clock, rising-edge active
//   reset  asynchronous active-low reset, forces q to 0
//   en     count enable (active-high)
//   up     direction: 1 = increment, 0 = decrement
//   load   synchronous parallel load (active-high, overrides en)
//   d      load value; values above MAX_COUNT load as 0
//   q      registered count, never exceeds MAX_COUNT
//   tc     terminal count (q == MAX_COUNT counting up, q == 0 counting down)
module contador_bcd #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Priority load > en > hold. Out-of-range codes recover to the value the
  // counting direction would wrap to, so q can never leave 0..MAX_COUNT.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (d > MaxVal) ? '0 : d;
    end else if (en) begin
      if (up) begin
        count_d = (count_q >= MaxVal) ? '0 : count_q + WIDTH'(1);
      end else begin
        if ((count_q == '0) || (count_q > MaxVal)) begin
          count_d = MaxVal;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q  = count_q;
  // Decoded straight from the register, so it only changes with q (or up).
  assign tc = up ? (count_q == MaxVal) : (count_q == '0);

endmodule

// File: tb/tb_contador_bcd.sv
// Testbench for contador_bcd: directed vectors with hand-computed expected
// values pushed into a scoreboard queue; a monitor pops and compares on each
// sample strobe (falling clock edge, or an explicit strobe between edges for
// asynchronous reset checks).
module tb_contador_bcd;

  typedef struct {
    string       name;
    int          unit;
    int unsigned eq;
    bit          etc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  event sample_ev;

  logic clk = 1'b0;

  // Main instance
  logic       rst, en, up, load;
  logic [3:0] d, q_m;
  logic       tc_m;
  // Cascade pair
  logic       rst_c, en_c, clk_c;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi;
  // MAX_COUNT = 5 build
  logic       rst_5, en_5;
  logic [3:0] q_5;
  logic       tc_5;
  logic       one, zero;
  logic [3:0] zero4;

  assign one   = 1'b1;
  assign zero  = 1'b0;
  assign zero4 = 4'd0;
  assign clk_c = ~(q_lo >= 4'd9);

  contador_bcd #(.WIDTH(4), .MAX_COUNT(9)) u_main (
    .clk(clk), .reset(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q_m), .tc(tc_m)
  );

  contador_bcd #(.WIDTH(4), .MAX_COUNT(9)) u_lo (
    .clk(clk), .reset(rst_c), .en(en_c), .up(one), .load(zero), .d(zero4),
    .q(q_lo), .tc(tc_lo)
  );

  contador_bcd #(.WIDTH(4), .MAX_COUNT(9)) u_hi (
    .clk(clk_c), .reset(rst_c), .en(one), .up(one), .load(zero), .d(zero4),
    .q(q_hi), .tc(tc_hi)
  );

  contador_bcd #(.WIDTH(4), .MAX_COUNT(5)) u_m5 (
    .clk(clk), .reset(rst_5), .en(en_5), .up(one), .load(zero), .d(zero4),
    .q(q_5), .tc(tc_5)
  );

  always #5 clk = ~clk;

  always @(negedge clk) -> sample_ev;

  // Monitor: drain every pending expectation at each sample strobe.
  initial begin
    exp_t       it;
    logic [3:0] aq;
    logic       at;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.unit)
          0:       begin aq = q_m;  at = tc_m;  end
          1:       begin aq = q_lo; at = tc_lo; end
          2:       begin aq = q_hi; at = tc_hi; end
          default: begin aq = q_5;  at = tc_5;  end
        endcase
        checks++;
        if (aq !== 4'(it.eq) || at !== it.etc) begin
          fails++;
          $display("FAIL %s: got q=%0d tc=%0b, expected q=%0d tc=%0b",
                   it.name, aq, at, it.eq, it.etc);
        end
      end
    end
  end

  task automatic push(input string nm, input int u, input int unsigned eq, input bit etc);
    exp_t e;
    e.name = nm; e.unit = u; e.eq = eq; e.etc = etc;
    sb.push_back(e);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // One clock edge on the main instance followed by one expectation.
  task automatic step(input string nm, input int unsigned eq, input bit etc);
    clk_edge();
    push(nm, 0, eq, etc);
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst_c = 1'b1; rst_5 = 1'b1;
    en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
    en_c = 1'b0; en_5 = 1'b0;
    #1;
    rst = 1'b0; rst_c = 1'b0; rst_5 = 1'b0;
    #2;
    push("reset_main", 0, 0, 1'b0);
    push("reset_lo",   1, 0, 1'b0);
    push("reset_hi",   2, 0, 1'b0);
    push("reset_m5",   3, 0, 1'b0);
    -> sample_ev;
    settle();
    rst = 1'b1; rst_c = 1'b1; rst_5 = 1'b1;

    // Bring q to 5, then pulse reset between edges.
    load = 1'b1; d = 4'd5;
    step("load5", 5, 1'b0);
    load = 1'b0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    push("async_reset", 0, 0, 1'b0);
    -> sample_ev;
    settle();

    // Count up 12 edges: 1..9,0,1,2
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step($sformatf("up_%0d", i), i % 10, (i % 10) == 9);
    end

    // Loads
    en = 1'b0; load = 1'b1; d = 4'd7;
    step("load7_en0", 7, 1'b0);
    d = 4'd12;
    step("load12_clamp", 0, 1'b0);
    en = 1'b1; d = 4'd3;
    step("load3_en1", 3, 1'b0);
    en = 1'b0; d = 4'd9;
    step("load9_tc", 9, 1'b1);
    d = 4'd15;
    step("load15_clamp", 0, 1'b0);
    d = 4'd2;
    step("load2", 2, 1'b0);

    // Count down from 2: 1,0,9,8
    load = 1'b0; up = 1'b0; en = 1'b1;
    step("down_1", 1, 1'b0);
    step("down_0", 0, 1'b1);
    step("down_9", 9, 1'b0);
    step("down_8", 8, 1'b0);

    // Hold at 4
    up = 1'b1; en = 1'b0; load = 1'b1; d = 4'd4;
    step("load4", 4, 1'b0);
    load = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("hold_%0d", i), 4, 1'b0);
    end

    // Cascade: high digit advances once per low-digit wrap
    en_c = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      clk_edge();
      push($sformatf("casc_lo_%0d", i), 1, i % 10, (i % 10) == 9);
      push($sformatf("casc_hi_%0d", i), 2, i / 10, 1'b0);
      settle();
    end
    en_c = 1'b0;

    // MAX_COUNT = 5: 1..5,0,1
    en_5 = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      clk_edge();
      push($sformatf("m5_%0d", i), 3, i % 6, (i % 6) == 5);
      settle();
    end
    en_5 = 1'b0;

    settle();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
